fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 31 +++
 rtl/fetch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_pkg
//   Shared definitions for the instruction fetch controller: datapath width,
//   PC increment, redirect alignment mask, FSM state encodings and the
//   next-sequential-PC helper.
//   Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN (adds S_FAULT).
// ----------------------------------------------------------------------------
package fetch_ctrl_pkg;

   localparam int unsigned REG_WIDTH = 32;

   localparam logic [REG_WIDTH-1:0] PC_STEP    = REG_WIDTH'(4);
   localparam logic [REG_WIDTH-1:0] ALIGN_MASK = {{(REG_WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_DROP  = 3'd2,
      S_HOLD  = 3'd3
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      ,
      S_FAULT = 3'd4
`endif
   } fetch_state_e;

   // Sequential successor; wraps silently at the top of the address space.
   function automatic logic [REG_WIDTH-1:0] pc_next(input logic [REG_WIDTH-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//   Single-outstanding-request instruction fetch controller. Issues one read
//   at a time to instruction memory, holds the returned word for the
//   consumer, and follows branch/jump redirects (redirect has priority over
//   every other event). All outputs are registered.
//
//   Ports
//     clk              single clock, rising edge
//     rst_n            synchronous active-low reset
//     stall            consumer not accepting the held instruction
//     redirect_valid   one-cycle taken branch/jump pulse
//     redirect_target  new fetch address
//     imem_req/addr    memory read request / address (stable until ack)
//     imem_ack/rdata   memory read complete / fetched word
//     inst_valid       inst and inst_pc are valid
//     inst / inst_pc   held instruction and its address
//     fetch_fault      misaligned redirect trapped (0 unless trap enabled)
//
//   Optional feature macro: FETCH_CTRL_MISALIGN_TRAP_EN
//     defined   : misaligned redirect target enters S_FAULT, no requests
//                 until reset or an aligned redirect
//     undefined : redirect_target[1:0] forced to 2'b00, fetch_fault tied 0
// ----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [REG_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [REG_WIDTH-1:0] redirect_target,
   output logic                 imem_req,
   output logic [REG_WIDTH-1:0] imem_addr,
   input  logic                 imem_ack,
   input  logic [REG_WIDTH-1:0] imem_rdata,
   output logic                 inst_valid,
   output logic [REG_WIDTH-1:0] inst,
   output logic [REG_WIDTH-1:0] inst_pc,
   output logic                 fetch_fault
);

   fetch_state_e         state_q, state_d;
   logic [REG_WIDTH-1:0] pc_q, pc_d;
   logic                 req_q, req_d;
   logic [REG_WIDTH-1:0] addr_q, addr_d;
   logic                 valid_q, valid_d;
   logic [REG_WIDTH-1:0] inst_q, inst_d;
   logic [REG_WIDTH-1:0] inst_pc_q, inst_pc_d;

   logic [REG_WIDTH-1:0] tgt;
   logic                 go_req;
   logic [REG_WIDTH-1:0] go_addr;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   // Raw target is kept so the alignment check can see the low bits.
   assign tgt = redirect_target;
`else
   assign tgt = redirect_target & ALIGN_MASK;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_d     = req_q;
      addr_d    = addr_q;
      valid_d   = valid_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      go_req    = 1'b0;
      go_addr   = pc_q;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      fault_d   = fault_q;
`endif

      case (state_q)
         S_IDLE: begin
            go_req  = 1'b1;
            go_addr = redirect_valid ? tgt : pc_q;
         end

         S_REQ: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = tgt;
               if (imem_ack) begin
                  go_req  = 1'b1;
                  go_addr = tgt;
               end else begin
                  // Request must complete on the bus; its data is discarded.
                  state_d = S_DROP;
               end
            end else if (imem_ack) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               pc_d      = pc_next(pc_q);
               valid_d   = 1'b1;
               req_d     = 1'b0;
               state_d   = S_HOLD;
            end
         end

         S_DROP: begin
            if (redirect_valid) begin
               pc_d = tgt;
            end
            if (imem_ack) begin
               go_req  = 1'b1;
               go_addr = redirect_valid ? tgt : pc_q;
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               go_req  = 1'b1;
               go_addr = tgt;
            end else if (!stall) begin
               valid_d = 1'b0;
               go_req  = 1'b1;
               go_addr = pc_q;
            end
         end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
         S_FAULT: begin
            if (redirect_valid) begin
               go_req  = 1'b1;
               go_addr = tgt;
            end
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Common entry into a new fetch; a misaligned address diverts to fault.
      if (go_req) begin
         pc_d = go_addr;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
         if (go_addr[1:0] != 2'b00) begin
            state_d = S_FAULT;
            req_d   = 1'b0;
            fault_d = 1'b1;
         end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = go_addr;
            fault_d = 1'b0;
         end
`else
         state_d = S_REQ;
         req_d   = 1'b1;
         addr_d  = go_addr;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         req_q     <= 1'b0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
         fault_q   <= fault_d;
`endif
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. Inputs change 2 time units after each
//   rising edge; outputs are compared on the falling edge against a
//   transaction-level model, and hand-computed literals are checked after
//   selected edges.
//   Honours FETCH_CTRL_MISALIGN_TRAP_EN for the misaligned-redirect case.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .fetch_fault     (fetch_fault)
   );

   always #5 clk = ~clk;

   // Memory contents: address 0 holds 32'h00500093, each word differs.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 + a;
   endfunction

   // Model: what the fetch unit must present, tracked as pending request,
   // held word, discard flag and fault flag.
   logic        m_req, m_valid, m_fault, m_drop;
   logic [31:0] m_addr, m_inst, m_ipc, m_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      return t;
`else
      return t & 32'hFFFF_FFFC;
`endif
   endfunction

   task automatic m_start(input logic [31:0] a);
      m_pc   = a;
      m_drop = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      if (a[1:0] != 2'b00) begin
         m_fault = 1'b1;
         m_req   = 1'b0;
         return;
      end
`endif
      m_fault = 1'b0;
      m_req   = 1'b1;
      m_addr  = a;
   endtask

   task automatic m_reset();
      m_pc = RST_PC; m_req = 1'b0; m_addr = '0; m_valid = 1'b0;
      m_inst = '0; m_ipc = '0; m_fault = 1'b0; m_drop = 1'b0;
   endtask

   task automatic m_update();
      logic [31:0] t;
      if (!rst_n) begin
         m_reset();
         return;
      end
      t = eff_target(redirect_target);
      if (m_req) begin
         if (imem_ack) begin
            m_req = 1'b0;
            if (redirect_valid)  m_start(t);
            else if (m_drop)     m_start(m_pc);
            else begin
               m_inst  = imem_rdata;
               m_ipc   = m_addr;
               m_valid = 1'b1;
               m_pc    = m_addr + 32'd4;
            end
         end else if (redirect_valid) begin
            m_pc   = t;
            m_drop = 1'b1;
         end
      end else if (m_valid) begin
         if (redirect_valid) begin
            m_valid = 1'b0;
            m_start(t);
         end else if (!stall) begin
            m_valid = 1'b0;
            m_start(m_pc);
         end
      end else if (m_fault) begin
         if (redirect_valid) m_start(t);
      end else begin
         m_start(redirect_valid ? t : m_pc);
      end
   endtask

   task automatic compare();
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      if (m_req) chk("imem_addr", imem_addr, m_addr);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("inst", inst, m_inst);
         chk("inst_pc", inst_pc, m_ipc);
      end
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
   endtask

   // One clock: apply inputs, check outputs mid-cycle, advance model,
   // return 2 units after the edge that consumed the inputs.
   task automatic step(input logic r, input logic ack, input logic st,
                       input logic rv, input logic [31:0] rt);
      rst_n           = r;
      imem_ack        = ack;
      imem_rdata      = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      @(negedge clk);
      compare();
      m_update();
      @(posedge clk);
      #2;
   endtask

   task automatic lit_fetch(input string name, input logic [31:0] a);
      chk({name, ".req"}, {31'd0, imem_req}, 32'd1);
      chk({name, ".addr"}, imem_addr, a);
   endtask

   task automatic lit_hold(input string name, input logic [31:0] pc, input logic [31:0] w);
      chk({name, ".valid"}, {31'd0, inst_valid}, 32'd1);
      chk({name, ".pc"}, inst_pc, pc);
      chk({name, ".inst"}, inst, w);
      chk({name, ".req"}, {31'd0, imem_req}, 32'd0);
   endtask

   initial begin
      m_reset();
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; imem_ack = 1'b0; imem_rdata = '0;
      @(posedge clk);
      #2;

      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.addr", imem_addr, 32'h0);
      chk("rst.valid", {31'd0, inst_valid}, 32'd0);
      chk("rst.fault", {31'd0, fetch_fault}, 32'd0);

      // Sequential fetch, ack on first request cycle
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("seq0", 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("seq0", 32'h0, 32'h0050_0093);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("seq4", 32'h4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("seq4", 32'h4, 32'h0050_0097);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("seq8", 32'h8);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("seq8", 32'h8, 32'h0050_009B);

      // Stall holds the word for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
         lit_hold("stall", 32'h8, 32'h0050_009B);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("resume", 32'hC);

      // Redirect while ack delayed: old address held, data dropped
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
      lit_fetch("drop1", 32'hC);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("drop2", 32'hC);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("drop.valid", {31'd0, inst_valid}, 32'd0);
      lit_fetch("drop.new", 32'h100);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("at100", 32'h100, 32'h0050_0193);

      // Redirect coincident with ack
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("seq104", 32'h104);
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
      chk("coin.valid", {31'd0, inst_valid}, 32'd0);
      lit_fetch("coin.new", 32'h200);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("at200", 32'h200, 32'h0050_0293);

      // Redirect beats stall in hold
      step(1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
      chk("hold_rd.valid", {31'd0, inst_valid}, 32'd0);
      lit_fetch("hold_rd", 32'h400);

      // Redirects during drop: last target wins
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h500);
      lit_fetch("drop_rd1", 32'h400);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h600);
      lit_fetch("drop_rd2", 32'h400);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_fetch("drop_rd.new", 32'h600);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("at600", 32'h600, 32'h0050_0693);

      // Top-of-memory wrap
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      lit_fetch("top", 32'hFFFF_FFFC);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("top", 32'hFFFF_FFFC, 32'h0050_008F);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("wrap", 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

      // Misaligned redirect
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
      chk("mis.req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         chk("mis.fault_hold", {31'd0, fetch_fault}, 32'd1);
         chk("mis.req_hold", {31'd0, imem_req}, 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
      chk("mis.clear", {31'd0, fetch_fault}, 32'd0);
      lit_fetch("mis.recover", 32'h300);
`else
      chk("mis.fault", {31'd0, fetch_fault}, 32'd0);
      lit_fetch("mis.align", 32'h100);
`endif

      // Reset abandons the outstanding request
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst2.req", {31'd0, imem_req}, 32'd0);
      chk("rst2.addr", imem_addr, 32'h0);
      chk("rst2.valid", {31'd0, inst_valid}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lit_fetch("rst2.first", RST_PC);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lit_hold("rst2", RST_PC, 32'h0050_0093);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
